// File: rtl/voxel_bin_pkg.sv
// Shared voxel-bin constants: classifier widths, sender FSM states and the
// address/beat derivations used by the feature stream sender.
package voxel_bin_pkg;

    localparam int unsigned CLASS_BITS  = 2;
    localparam int unsigned NUM_CLASSES = 4;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_START       = 2'd1,
        ST_STREAM      = 2'd2,
        ST_WAIT_RESULT = 2'd3
    } fss_state_e;

    function automatic int unsigned addr_bits_f(input int unsigned num_cells);
        return (num_cells > 32'd1) ? 32'($clog2(num_cells)) : 32'd1;
    endfunction

    function automatic int unsigned beats_f(input int unsigned num_cells,
                                            input int unsigned lanes);
        return (num_cells + lanes - 32'd1) / lanes;
    endfunction

    // Width able to hold the value 'limit' itself, never narrower than 1 bit.
    function automatic int unsigned cnt_bits_f(input int unsigned limit);
        return (limit > 32'd0) ? 32'($clog2(limit + 32'd1)) : 32'd1;
    endfunction

    function automatic int unsigned lane_index_f(input int unsigned batch,
                                                 input int unsigned lanes,
                                                 input int unsigned lane);
        return (batch * lanes) + lane;
    endfunction

endpackage

// File: rtl/beat_lane_mask.sv
// Per-lane cell address and in-range mask for one read batch; lanes that fall
// past the end of the grid get address 0 and a cleared mask bit.
module beat_lane_mask
    import voxel_bin_pkg::*;
#(
    parameter int unsigned NUM_CELLS       = 1024,
    parameter int unsigned PARALLEL_INPUTS = 4,
    parameter int unsigned ADDR_BITS       = 10,
    parameter int unsigned CNT_BITS        = 9
) (
    input  logic [CNT_BITS-1:0]                  batch_i,
    output logic [PARALLEL_INPUTS*ADDR_BITS-1:0] addr_flat_o,
    output logic [PARALLEL_INPUTS-1:0]           lane_ok_o
);

    // Lane address and padding decode
    always_comb begin
        addr_flat_o = '0;
        lane_ok_o   = '0;
        for (int p = 0; p < int'(PARALLEL_INPUTS); p++) begin
            if (lane_index_f(32'(batch_i), PARALLEL_INPUTS, 32'(p)) < NUM_CELLS) begin
                addr_flat_o[p*ADDR_BITS +: ADDR_BITS] =
                    ADDR_BITS'(lane_index_f(32'(batch_i), PARALLEL_INPUTS, 32'(p)));
                lane_ok_o[p] = 1'b1;
            end else begin
                addr_flat_o[p*ADDR_BITS +: ADDR_BITS] = '0;
                lane_ok_o[p] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/feature_stream_sender.sv
// Streams the voxel grid from memory to the classifier in gap-free beats,
// then waits (under a watchdog) for the classifier's winning class.
module feature_stream_sender
    import voxel_bin_pkg::*;
#(
    parameter int unsigned NUM_CELLS       = 1024,
    parameter int unsigned VALUE_BITS      = 6,
    parameter int unsigned PARALLEL_INPUTS = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 4096,
    localparam int unsigned ADDR_BITS      = addr_bits_f(NUM_CELLS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  frame_trigger,
    output logic                                  rd_en,
    output logic [PARALLEL_INPUTS*ADDR_BITS-1:0]  rd_addr_flat,
    input  logic [PARALLEL_INPUTS*VALUE_BITS-1:0] rd_data_flat,
    output logic                                  mm_start,
    output logic [PARALLEL_INPUTS*VALUE_BITS-1:0] feature_in,
    output logic                                  feature_valid,
    input  logic                                  result_valid,
    input  logic [CLASS_BITS-1:0]                 best_class,
    output logic [CLASS_BITS-1:0]                 class_out,
    output logic                                  class_valid,
    output logic                                  busy,
    output logic                                  drop_pulse,
    output logic                                  timeout_pulse
);

    localparam int unsigned BEATS    = beats_f(NUM_CELLS, PARALLEL_INPUTS);
    localparam int unsigned CNT_BITS = cnt_bits_f(BEATS);
    localparam int unsigned WD_BITS  = cnt_bits_f(TIMEOUT_CYCLES);
    localparam int unsigned AW       = PARALLEL_INPUTS * ADDR_BITS;
    localparam int unsigned DW       = PARALLEL_INPUTS * VALUE_BITS;

    localparam logic [CNT_BITS-1:0] LAST_BATCH = CNT_BITS'(BEATS - 32'd1);
    localparam logic [CNT_BITS-1:0] BEAT_TOTAL = CNT_BITS'(BEATS);
    localparam logic [WD_BITS-1:0]  WD_LIMIT   = WD_BITS'(TIMEOUT_CYCLES - 32'd1);

    fss_state_e state_q, state_d;

    logic [CNT_BITS-1:0]        bcnt_q, bcnt_d;
    logic [CNT_BITS-1:0]        fcnt_q, fcnt_d;
    logic [WD_BITS-1:0]         wd_q, wd_d;
    logic                       rd_en_q, rd_en_d;
    logic [AW-1:0]              rd_addr_q, rd_addr_d;
    logic [PARALLEL_INPUTS-1:0] lane_ok_q, lane_ok_d;
    logic                       rvld_q, rvld_d;
    logic [PARALLEL_INPUTS-1:0] rok_q, rok_d;
    logic                       mm_start_q, mm_start_d;
    logic [DW-1:0]              feature_q, feature_d;
    logic                       fvalid_q, fvalid_d;
    logic [CLASS_BITS-1:0]      class_q, class_d;
    logic                       class_valid_q, class_valid_d;
    logic                       drop_q, drop_d;
    logic                       timeout_q, timeout_d;
    logic                       busy_q, busy_d;

    logic                       issue_s;
    logic [CNT_BITS-1:0]        bnext_s;
    logic [AW-1:0]              lane_addr_s;
    logic [PARALLEL_INPUTS-1:0] lane_ok_s;

    beat_lane_mask #(
        .NUM_CELLS       (NUM_CELLS),
        .PARALLEL_INPUTS (PARALLEL_INPUTS),
        .ADDR_BITS       (ADDR_BITS),
        .CNT_BITS        (CNT_BITS)
    ) u_beat_lane_mask (
        .batch_i     (bnext_s),
        .addr_flat_o (lane_addr_s),
        .lane_ok_o   (lane_ok_s)
    );

    // Decide whether a read batch goes out next cycle, and which one
    always_comb begin
        issue_s = 1'b0;
        bnext_s = '0;
        case (state_q)
            ST_IDLE: begin
                issue_s = frame_trigger;
                bnext_s = '0;
            end
            ST_START, ST_STREAM: begin
                if (rd_en_q && (bcnt_q < LAST_BATCH)) begin
                    issue_s = 1'b1;
                    bnext_s = bcnt_q + CNT_BITS'(1);
                end else begin
                    issue_s = 1'b0;
                    bnext_s = '0;
                end
            end
            default: begin
                issue_s = 1'b0;
                bnext_s = '0;
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        rd_en_d       = issue_s;
        rd_addr_d     = issue_s ? lane_addr_s : '0;
        lane_ok_d     = issue_s ? lane_ok_s : '0;
        bcnt_d        = issue_s ? bnext_s : bcnt_q;
        rvld_d        = rd_en_q;
        rok_d         = lane_ok_q;
        fvalid_d      = rvld_q;
        feature_d     = '0;
        fcnt_d        = fcnt_q;
        wd_d          = '0;
        mm_start_d    = 1'b0;
        class_d       = class_q;
        class_valid_d = 1'b0;
        drop_d        = 1'b0;
        timeout_d     = 1'b0;

        // Read data lands one cycle after the strobe; padding lanes are forced to 0
        for (int p = 0; p < int'(PARALLEL_INPUTS); p++) begin
            if (rvld_q && rok_q[p]) begin
                feature_d[p*VALUE_BITS +: VALUE_BITS] = rd_data_flat[p*VALUE_BITS +: VALUE_BITS];
            end else begin
                feature_d[p*VALUE_BITS +: VALUE_BITS] = '0;
            end
        end
        if (rvld_q) begin
            fcnt_d = fcnt_q + CNT_BITS'(1);
        end else begin
            fcnt_d = fcnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_trigger) begin
                    state_d    = ST_START;
                    mm_start_d = 1'b1;
                    fcnt_d     = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_START: begin
                drop_d  = frame_trigger;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                drop_d = frame_trigger;
                if (fvalid_q && (fcnt_q == BEAT_TOTAL)) begin
                    state_d = ST_WAIT_RESULT;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_WAIT_RESULT: begin
                drop_d = frame_trigger;
                // A result arriving on the expiry cycle takes priority over the timeout
                if (result_valid) begin
                    class_d       = best_class;
                    class_valid_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (wd_q == WD_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, read pipeline and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q        <= '0;
            fcnt_q        <= '0;
            wd_q          <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            lane_ok_q     <= '0;
            rvld_q        <= 1'b0;
            rok_q         <= '0;
            mm_start_q    <= 1'b0;
            feature_q     <= '0;
            fvalid_q      <= 1'b0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            drop_q        <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            bcnt_q        <= bcnt_d;
            fcnt_q        <= fcnt_d;
            wd_q          <= wd_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            lane_ok_q     <= lane_ok_d;
            rvld_q        <= rvld_d;
            rok_q         <= rok_d;
            mm_start_q    <= mm_start_d;
            feature_q     <= feature_d;
            fvalid_q      <= fvalid_d;
            class_q       <= class_d;
            class_valid_q <= class_valid_d;
            drop_q        <= drop_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign rd_en         = rd_en_q;
    assign rd_addr_flat  = rd_addr_q;
    assign mm_start      = mm_start_q;
    assign feature_in    = feature_q;
    assign feature_valid = fvalid_q;
    assign class_out     = class_q;
    assign class_valid   = class_valid_q;
    assign busy          = busy_q;
    assign drop_pulse    = drop_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_feature_stream_sender.sv
// Directed bench: a 16-cell grid (exact beats) and a 10-cell grid (padding),
// both with an 8-cycle result watchdog.
module tb_feature_stream_sender;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        trig_a, rd_en_a, mm_a, fv_a, rv_a, cv_a, busy_a, drop_a, to_a;
    logic [15:0] addr_a;
    logic [23:0] rdd_a = 24'h0;
    logic [23:0] fin_a;
    logic [1:0]  bc_a, co_a;

    logic        trig_b, rd_en_b, mm_b, fv_b, rv_b, cv_b, busy_b, drop_b, to_b;
    logic [15:0] addr_b;
    logic [23:0] rdd_b = 24'h0;
    logic [23:0] fin_b;
    logic [1:0]  bc_b, co_b;

    int n_total = 0;
    int n_pass  = 0;
    int beats_a = 0;
    int starts_a = 0;

    feature_stream_sender #(
        .NUM_CELLS(16), .VALUE_BITS(6), .PARALLEL_INPUTS(4), .TIMEOUT_CYCLES(8)
    ) dut_a (
        .clk(clk), .rst(rst), .frame_trigger(trig_a), .rd_en(rd_en_a),
        .rd_addr_flat(addr_a), .rd_data_flat(rdd_a), .mm_start(mm_a),
        .feature_in(fin_a), .feature_valid(fv_a), .result_valid(rv_a),
        .best_class(bc_a), .class_out(co_a), .class_valid(cv_a), .busy(busy_a),
        .drop_pulse(drop_a), .timeout_pulse(to_a)
    );

    feature_stream_sender #(
        .NUM_CELLS(10), .VALUE_BITS(6), .PARALLEL_INPUTS(4), .TIMEOUT_CYCLES(8)
    ) dut_b (
        .clk(clk), .rst(rst), .frame_trigger(trig_b), .rd_en(rd_en_b),
        .rd_addr_flat(addr_b), .rd_data_flat(rdd_b), .mm_start(mm_b),
        .feature_in(fin_b), .feature_valid(fv_b), .result_valid(rv_b),
        .best_class(bc_b), .class_out(co_b), .class_valid(cv_b), .busy(busy_b),
        .drop_pulse(drop_b), .timeout_pulse(to_b)
    );

    // Memory for grid A: each lane returns its own address (mod 64)
    always @(posedge clk) begin
        if (rd_en_a) begin
            for (int p = 0; p < 4; p++) begin
                rdd_a[p*6 +: 6] <= 6'(addr_a[p*4 +: 4]);
            end
        end
    end

    // Memory for grid B: every lane returns 63
    always @(posedge clk) begin
        if (rd_en_b) begin
            rdd_b <= 24'hFFFFFF;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one cycle and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (fv_a === 1'b1) beats_a++;
        if (mm_a === 1'b1) starts_a++;
    endtask

    initial begin
        trig_a = 1'b0; rv_a = 1'b0; bc_a = 2'd0;
        trig_b = 1'b0; rv_b = 1'b0; bc_b = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   64'(busy_a), 64'd0);
        check("rst_rd_en",  64'(rd_en_a), 64'd0);
        check("rst_addr",   64'(addr_a), 64'd0);
        check("rst_fv",     64'(fv_a), 64'd0);
        check("rst_fin",    64'(fin_a), 64'd0);
        check("rst_misc",   64'({mm_a, cv_a, drop_a, to_a, co_a}), 64'd0);
        rst = 1'b0;

        // Frame 1 on A: trigger in cycle 0
        beats_a = 0; starts_a = 0;
        trig_a = 1'b1;
        tick(); trig_a = 1'b0;                                   // cycle 1
        check("c1_mm_start", 64'(mm_a), 64'd1);
        check("c1_rd_en",    64'(rd_en_a), 64'd1);
        check("c1_addr",     64'(addr_a), 64'h3210);
        check("c1_fv",       64'(fv_a), 64'd0);
        tick();                                                  // cycle 2
        check("c2_addr",     64'(addr_a), 64'h7654);
        check("c2_fin_idle", 64'({fv_a, fin_a}), 64'd0);
        tick();                                                  // cycle 3
        check("c3_fv",       64'(fv_a), 64'd1);
        check("c3_beat0",    64'(fin_a), 64'({6'd3, 6'd2, 6'd1, 6'd0}));
        check("c3_mm_start", 64'(mm_a), 64'd0);
        trig_a = 1'b1;
        tick(); trig_a = 1'b0;                                   // cycle 4
        check("c4_beat1",    64'(fin_a), 64'({6'd7, 6'd6, 6'd5, 6'd4}));
        check("c4_drop",     64'(drop_a), 64'd1);
        tick();                                                  // cycle 5
        check("c5_beat2",    64'(fin_a), 64'({6'd11, 6'd10, 6'd9, 6'd8}));
        check("c5_drop_off", 64'(drop_a), 64'd0);
        tick();                                                  // cycle 6
        check("c6_beat3",    64'(fin_a), 64'({6'd15, 6'd14, 6'd13, 6'd12}));
        tick();                                                  // cycle 7
        check("c7_fv_off",   64'({fv_a, fin_a}), 64'd0);
        check("c7_busy",     64'(busy_a), 64'd1);
        check("f1_beats",    64'(beats_a), 64'd4);
        check("f1_starts",   64'(starts_a), 64'd1);
        repeat (4) tick();                                       // cycle 11
        rv_a = 1'b1; bc_a = 2'd2;
        tick(); rv_a = 1'b0; bc_a = 2'd0;                        // cycle 12
        check("res_cv",      64'(cv_a), 64'd1);
        check("res_class",   64'(co_a), 64'd2);
        check("res_busy",    64'(busy_a), 64'd0);
        tick();                                                  // cycle 13
        check("res_cv_once", 64'(cv_a), 64'd0);

        // Result pulse while idle is ignored
        rv_a = 1'b1; bc_a = 2'd3;
        tick(); rv_a = 1'b0; bc_a = 2'd0;
        check("idle_res_cv",    64'(cv_a), 64'd0);
        check("idle_res_class", 64'(co_a), 64'd2);

        // Watchdog expiry: WAIT_RESULT entered 7 cycles after the trigger
        trig_a = 1'b1;
        tick(); trig_a = 1'b0;
        repeat (6) tick();                                       // E
        check("wd_entry_busy", 64'({busy_a, fv_a}), 64'b10);
        repeat (7) tick();                                       // E+7
        check("wd_pre_to",     64'({to_a, busy_a}), 64'b01);
        tick();                                                  // E+8
        check("wd_timeout",    64'(to_a), 64'd1);
        check("wd_idle",       64'(busy_a), 64'd0);
        check("wd_class_kept", 64'({cv_a, co_a}), 64'({1'b0, 2'd2}));
        tick();
        check("wd_to_once",    64'(to_a), 64'd0);

        // Result on the expiry cycle wins over the timeout
        trig_a = 1'b1;
        tick(); trig_a = 1'b0;
        repeat (6) tick();                                       // E
        repeat (7) tick();                                       // E+7
        rv_a = 1'b1; bc_a = 2'd1;
        tick(); rv_a = 1'b0; bc_a = 2'd0;                        // E+8
        check("race_cv",    64'(cv_a), 64'd1);
        check("race_no_to", 64'(to_a), 64'd0);
        check("race_class", 64'(co_a), 64'd1);
        check("race_busy",  64'(busy_a), 64'd0);

        // Asynchronous reset in the middle of the stream
        trig_a = 1'b1;
        tick(); trig_a = 1'b0;
        tick(); tick();
        check("mid_fv_on", 64'(fv_a), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_fv_fin", 64'({fv_a, fin_a}), 64'd0);
        check("arst_rd",     64'({rd_en_a, addr_a}), 64'd0);
        check("arst_ctrl",   64'({busy_a, mm_a, co_a}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Clean frame after reset
        beats_a = 0; starts_a = 0;
        trig_a = 1'b1;
        tick(); trig_a = 1'b0;
        check("post_mm",    64'(mm_a), 64'd1);
        check("post_addr",  64'(addr_a), 64'h3210);
        tick(); tick();
        check("post_beat0", 64'(fin_a), 64'({6'd3, 6'd2, 6'd1, 6'd0}));
        repeat (3) tick();
        check("post_beat3", 64'(fin_a), 64'({6'd15, 6'd14, 6'd13, 6'd12}));
        tick();
        check("post_fv_off", 64'(fv_a), 64'd0);
        check("post_beats",  64'(beats_a), 64'd4);
        check("post_starts", 64'(starts_a), 64'd1);

        // Grid B: 10 cells, last beat has two padding lanes
        trig_b = 1'b1;
        tick(); trig_b = 1'b0;                                   // c+1
        check("b_addr0", 64'(addr_b), 64'h3210);
        tick(); tick();                                          // c+3
        check("b_addr2_pad", 64'(addr_b), 64'h0098);
        check("b_beat0",     64'(fin_b), 64'hFFFFFF);
        tick(); tick();                                          // c+5
        check("b_beat2_pad", 64'({fv_b, fin_b}), 64'({1'b1, 24'h000FFF}));
        tick();                                                  // c+6
        check("b_end",       64'({fv_b, busy_b}), 64'b01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
